dm_arbiter: RTL and testbench

Two-port arbiter sharing the single-ported, synchronous-read data memory (DRAM, 2K x 32 words) between the RISC0 CPU load/store path and a DMA requester such as a display refresh or block-transfer engine. One memory access is granted per clock. The CPU normally has priority and is stalled while it loses. An optional anti-starvation counter forces a DMA grant after a bounded run of contested CPU wins. The block sits between the CPU's dmadr/dmin/dmwr signals and the DRAM instance.

---
 rtl/dm_arbiter.sv | 69 ++++++
 tb/tb_dm_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU/DMA arbiter for the single-ported data RAM; define DM_ARB_FAIR_EN to force DMA after STARVE contested CPU wins.
module dm_arbiter #(
    parameter int AW     = 11,
    parameter int DW     = 32,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_dout,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_din,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_dout,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);
    if (STARVE < 1 || STARVE > 15) begin : g_bad_starve
        $error("dm_arbiter: STARVE must be 1..15");
    end
    logic cpu_gnt, force_dma;
    logic own_dma_q, own_dma_d, rd_q, rd_d;
`ifdef DM_ARB_FAIR_EN
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        force_dma = cpu_req & dma_req & (cnt_q == 4'(STARVE));
        cnt_d     = (!dma_req || dma_gnt) ? 4'd0 : (cpu_req ? cnt_q + 4'd1 : cnt_q);
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end
`else
    assign force_dma = 1'b0;
`endif
    always_comb begin
        cpu_gnt   = cpu_req & ~force_dma;
        dma_gnt   = dma_req & ~cpu_gnt;
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_adr   = dma_gnt ? dma_adr : cpu_adr;
        mem_din   = dma_gnt ? dma_din : cpu_din;
        mem_we    = dma_gnt ? dma_we : (cpu_gnt & cpu_we);
        rd_d      = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        own_dma_d = dma_gnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= 1'b0;
            own_dma_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            own_dma_q <= own_dma_d;
        end
    end
    assign cpu_rvalid = rd_q & ~own_dma_q;
    assign dma_rvalid = rd_q & own_dma_q;
    assign cpu_dout   = mem_dout;
    assign dma_dout   = mem_dout;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed plus randomized checks of dm_arbiter against a cycle-level reference model.
module tb_dm_arbiter;
    localparam int AW = 11, DW = 32, STARVE = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [AW-1:0] cpu_adr = '0, dma_adr = '0, mem_adr;
    logic [DW-1:0] cpu_din = '0, dma_din = '0, mem_din, mem_dout, cpu_dout, dma_dout;
    logic cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
    logic [DW-1:0] ram [0:2047];
    logic [DW-1:0] ref_mem [0:2047];
    int tests = 0, fails = 0, cnt = 0;
    logic exp_crv = 1'b0, exp_drv = 1'b0;
    logic [DW-1:0] exp_dat = '0;
    logic gc, gd;
    dm_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_din(cpu_din),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_din(dma_din),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_dout(dma_dout),
        .mem_adr(mem_adr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_din;
        mem_dout <= ram[mem_adr];
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic creq, input logic cwe, input logic [AW-1:0] cadr,
                        input logic [DW-1:0] cdin, input logic dreq, input logic dwe,
                        input logic [AW-1:0] dadr, input logic [DW-1:0] ddin,
                        output logic g_c, output logic g_d);
        logic fdma;
        @(negedge clk);
        rst = r; cpu_req = creq; cpu_we = cwe; cpu_adr = cadr; cpu_din = cdin;
        dma_req = dreq; dma_we = dwe; dma_adr = dadr; dma_din = ddin;
        #1;
`ifdef DM_ARB_FAIR_EN
        fdma = creq && dreq && cnt == STARVE;
`else
        fdma = 1'b0;
`endif
        g_c = creq & ~fdma;
        g_d = dreq & ~g_c;
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, creq & ~g_c});
        chk("dma_gnt", {31'b0, dma_gnt}, {31'b0, g_d});
        chk("mem_we", {31'b0, mem_we}, {31'b0, (g_c & cwe) | (g_d & dwe)});
        chk("mem_adr", {21'b0, mem_adr}, {21'b0, g_d ? dadr : cadr});
        if ((g_c & cwe) | (g_d & dwe)) chk("mem_din", mem_din, g_d ? ddin : cdin);
        chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, exp_crv});
        chk("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, exp_drv});
        if (exp_crv) chk("cpu_dout", cpu_dout, exp_dat);
        if (exp_drv) chk("dma_dout", dma_dout, exp_dat);
        @(posedge clk);
        exp_crv = ~r & g_c & ~cwe;
        exp_drv = ~r & g_d & ~dwe;
        exp_dat = ref_mem[g_d ? dadr : cadr];
        if (g_c & cwe) ref_mem[cadr] = cdin;
        if (g_d & dwe) ref_mem[dadr] = ddin;
        if (r || !dreq || g_d) cnt = 0;
        else if (creq) cnt++;
    endtask
    initial begin
        logic cr, cw, dr, dw;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] cd, dd;
        for (int i = 0; i < 2048; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        step(0, 1, 1, 11'h010, 32'h12345678, 0, 0, 0, 0, gc, gd);
        step(0, 1, 0, 11'h010, 0, 0, 0, 0, 0, gc, gd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        chk("plan_cpu_data", cpu_dout, 32'h12345678);
        step(0, 0, 0, 0, 0, 1, 1, 11'h7FF, 32'hCAFEF00D, gc, gd);
        step(0, 0, 0, 0, 0, 1, 0, 11'h7FF, 0, gc, gd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        chk("plan_dma_data", dma_dout, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 11'(i), 0, 1, 0, 11'h7FF, 0, gc, gd);
        step(0, 1, 0, 11'h010, 0, 0, 0, 0, 0, gc, gd);
        step(0, 0, 0, 0, 0, 1, 0, 11'h7FF, 0, gc, gd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        step(1, 1, 0, 11'h010, 0, 0, 0, 0, 0, gc, gd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        cr = 0; cw = 0; ca = 0; cd = 0; dr = 0; dw = 0; da = 0; dd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(cr && !gc)) begin
                cr = ($urandom_range(0, 3) != 0); cw = $urandom_range(0, 1) == 1;
                ca = 11'($urandom_range(0, 15)); cd = $urandom;
            end
            if (!(dr && !gd)) begin
                dr = ($urandom_range(0, 2) != 0); dw = $urandom_range(0, 1) == 1;
                da = 11'($urandom_range(0, 15)); dd = $urandom;
            end
            step(($urandom_range(0, 79) == 0), cr, cw, ca, cd, dr, dw, da, dd, gc, gd);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, gc, gd);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
